// File: rtl/pipeline_hazard_controller_pkg.sv
// pipeline_pkg: shared state encoding and default widths for the hazard controller.
package pipeline_pkg;
    localparam int DEF_CNT_WIDTH = 16;
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;
endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: hazard/memory inputs and freeze/flush/counter outputs of the controller.
interface pipeline_hazard_controller_if
    import pipeline_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
    logic                 hazard;
    logic                 branch_taken;
    logic                 mem_req;
    logic                 mem_ready;
    logic                 freeze_if;
    logic                 flush_if;
    logic                 flush_id;
    logic                 freeze_all;
    logic                 error;
    logic [CNT_WIDTH-1:0] stall_count;
    logic [CNT_WIDTH-1:0] flush_count;
    modport master (
        output hazard, branch_taken, mem_req, mem_ready,
        input  freeze_if, flush_if, flush_id, freeze_all, error, stall_count, flush_count
    );
    modport slave (
        input  hazard, branch_taken, mem_req, mem_ready,
        output freeze_if, flush_if, flush_id, freeze_all, error, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
    assign count_o = cnt_q;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: per-stage freeze/flush strobes, memory-wait FSM with
// timeout watchdog, and saturating stall/flush counters.
module pipeline_hazard_controller
    import pipeline_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int TIMEOUT   = 255,
    parameter int TO_WIDTH  = 8
) (
    input logic                         clk,
    input logic                         rst,
    pipeline_hazard_controller_if.slave bus_if
);
    state_e              state_q, state_d;
    logic [TO_WIDTH-1:0] wd_q, wd_d;
    logic                pend_q, pend_d;
    logic                err_q, err_d;
    logic                freeze_if, flush_if, flush_id, freeze_all;
    always_comb begin
        state_d    = state_q;
        wd_d       = wd_q;
        pend_d     = pend_q;
        err_d      = err_q;
        freeze_if  = 1'b0;
        flush_if   = 1'b0;
        flush_id   = 1'b0;
        freeze_all = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus_if.mem_req && !bus_if.mem_ready) begin
                    freeze_all = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wd_d       = TO_WIDTH'(1);
                    pend_d     = bus_if.branch_taken;
                end else if (bus_if.branch_taken) begin
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                end else if (bus_if.hazard) begin
                    freeze_if = 1'b1;
                    flush_id  = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (bus_if.mem_ready) begin
                    state_d = ST_RUN;
                    wd_d    = '0;
                    pend_d  = 1'b0;
                    // a branch resolved during the wait is killed on the release cycle
                    if (pend_q || bus_if.branch_taken) begin
                        flush_if = 1'b1;
                        flush_id = 1'b1;
                    end else if (bus_if.hazard) begin
                        freeze_if = 1'b1;
                        flush_id  = 1'b1;
                    end
                end else begin
                    freeze_all = 1'b1;
                    pend_d     = pend_q | bus_if.branch_taken;
                    if (wd_q == TO_WIDTH'(TIMEOUT)) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end
            default: begin
                freeze_all = 1'b1;
                state_d    = ST_ERROR;
                err_d      = 1'b1;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            wd_q    <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end
    // strobes are forced low while reset is held, whatever the inputs do
    assign bus_if.freeze_if  = rst & freeze_if;
    assign bus_if.flush_if   = rst & flush_if;
    assign bus_if.flush_id   = rst & flush_id;
    assign bus_if.freeze_all = rst & freeze_all;
    assign bus_if.error      = err_q;
    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (freeze_all | freeze_if),
        .count_o (bus_if.stall_count)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (flush_if),
        .count_o (bus_if.flush_count)
    );
endmodule
